// File: rtl/prefix_subtractor_pipe_16u.sv
// 16-bit unsigned subtractor (a - b) on a two-stage Kogge-Stone pipeline with valid/ready flow.
// Optional build macro SUB_SATURATE_EN clamps diff to zero whenever a borrow occurs.
module prefix_subtractor_pipe_16u (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] diff,
    output logic        bout
);

    logic        s1_v_q;
    logic        out_valid_q;
    logic [15:0] diff_q;
    logic        bout_q;
    logic        s1_en;
    logic        s2_en;

    // Stage-1 datapath registers: bit propagate, group generate/propagate after span-2 level
    logic [15:0] p_q;
    logic [15:0] gg_q;
    logic [15:4] gp_q;

    logic [15:0] p0;
    logic [15:0] g0;
    logic [15:0] g1;
    logic [15:2] p1;
    logic [15:0] g2;
    logic [15:4] p2;

    logic [15:0] g3;
    logic [15:8] p3;
    logic [15:0] g4;
    logic [15:0] carry;
    logic [15:0] sum;
    logic        borrow;
    logic [15:0] diff_d;

    assign s2_en    = !out_valid_q || out_ready;
    assign s1_en    = !s1_v_q || s2_en;
    assign in_ready = s1_en;

    always_comb begin
        p0 = a ^ ~b;
        g0 = a & ~b;
        // Carry-in of 1 from position -1 is absorbed into bit 0's generate.
        g0[0] = g0[0] | p0[0];

        g1 = g0;
        for (int i = 1; i < 16; i++) begin
            g1[i] = g0[i] | (p0[i] & g0[i-1]);
        end
        for (int i = 2; i < 16; i++) begin
            p1[i] = p0[i] & p0[i-1];
        end

        g2 = g1;
        for (int i = 2; i < 16; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
        end
        for (int i = 4; i < 16; i++) begin
            p2[i] = p1[i] & p1[i-2];
        end
    end

    always_comb begin
        g3 = gg_q;
        for (int i = 4; i < 16; i++) begin
            g3[i] = gg_q[i] | (gp_q[i] & gg_q[i-4]);
        end
        for (int i = 8; i < 16; i++) begin
            p3[i] = gp_q[i] & gp_q[i-4];
        end

        g4 = g3;
        for (int i = 8; i < 16; i++) begin
            g4[i] = g3[i] | (p3[i] & g3[i-8]);
        end

        carry  = {g4[14:0], 1'b1};
        sum    = p_q ^ carry;
        borrow = ~g4[15];
`ifdef SUB_SATURATE_EN
        diff_d = borrow ? 16'h0000 : sum;
`else
        diff_d = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            diff_q      <= 16'h0000;
            bout_q      <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_v_q <= in_valid;
            end
            if (s2_en) begin
                out_valid_q <= s1_v_q;
                if (s1_v_q) begin
                    diff_q <= diff_d;
                    bout_q <= borrow;
                end
            end
        end
    end

    // Contents are meaningless while s1_v_q is low, so no reset here.
    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            p_q  <= p0;
            gg_q <= g2;
            gp_q <= p2;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_prefix_subtractor_pipe_16u.sv
// Self-checking bench for prefix_subtractor_pipe_16u: directed cases plus randomized streams
// scored against an arithmetic reference queue.
module tb_prefix_subtractor_pipe_16u;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;

    int total = 0;
    int bad   = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    prefix_subtractor_pipe_16u dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    // Reference result {bout, diff}
    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] r;
        logic        bo;
        bo = (x < y);
        r  = x - y;
`ifdef SUB_SATURATE_EN
        if (bo) r = 16'h0000;
`endif
        return {bo, r};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 16'h0; b = 16'h0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (diff !== 16'h0000) begin bad++; $display("FAIL reset_diff: got %h want 0000", diff); end
        total++; if (bout !== 1'b0) begin bad++; $display("FAIL reset_bout: got %b want 0", bout); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        next_cycle();
    endtask

    // Directed single operations; latency of exactly two edges and a bubble afterwards.
    task automatic test_single();
        logic [15:0] ta [5];
        logic [15:0] tb [5];
        logic [15:0] td [5];
        logic        tbo[5];
        ta[0] = 16'h1234; tb[0] = 16'h0234; td[0] = 16'h1000; tbo[0] = 1'b0;
        ta[1] = 16'h0000; tb[1] = 16'h0001; td[1] = 16'hFFFF; tbo[1] = 1'b1;
        ta[2] = 16'hA5C3; tb[2] = 16'hA5C3; td[2] = 16'h0000; tbo[2] = 1'b0;
        ta[3] = 16'h0000; tb[3] = 16'hFFFF; td[3] = 16'h0001; tbo[3] = 1'b1;
        ta[4] = 16'hFFFF; tb[4] = 16'h0000; td[4] = 16'hFFFF; tbo[4] = 1'b0;
`ifdef SUB_SATURATE_EN
        td[1] = 16'h0000;
        td[3] = 16'h0000;
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; a = ta[k]; b = tb[k];
            @(negedge clk);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready[%0d]: got %b want 1", k, in_ready); end
            next_cycle();
            in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early[%0d]: got %b want 0", k, out_valid); end
            next_cycle();
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid[%0d]: got %b want 1", k, out_valid); end
            total++; if (diff !== td[k]) begin bad++; $display("FAIL single_diff[%0d]: got %h want %h", k, diff, td[k]); end
            total++; if (bout !== tbo[k]) begin bad++; $display("FAIL single_bout[%0d]: got %b want %b", k, bout, tbo[k]); end
            next_cycle();
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_bubble[%0d]: got %b want 0", k, out_valid); end
            next_cycle();
        end
    endtask

    task automatic test_stream();
        int accepted = 0;
        logic [16:0] e;
        out_ready = 1'b1;
        for (int c = 0; c < 70; c++) begin
            in_valid = (accepted < 64);
            a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            if (in_valid) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, in_ready); end
            end
            if (in_valid && in_ready) begin exp_q.push_back(model(a, b)); accepted++; end
            if (c >= 2 && c < 66) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_no_bubble c=%0d: got %b want 1", c, out_valid); end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got %h/%b want nothing", diff, bout); end
                else begin
                    e = exp_q.pop_front();
                    if ({bout, diff} !== e) begin bad++; $display("FAIL stream_data: got %b/%h want %b/%h", bout, diff, e[16], e[15:0]); end
                end
            end
            next_cycle();
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stream_lost: got %0d pending want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        int c = 0;
        logic take;
        logic [16:0] held;
        logic [16:0] e;
        held = '0;
        a = 16'($urandom); b = 16'($urandom);
        while ((accepted < 20 || exp_q.size() != 0) && c < 200) begin
            out_ready = !(c >= 5 && c < 10);
            in_valid = (accepted < 20);
            @(negedge clk);
            if (c >= 5 && c < 10) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d: got %b want 0", c, in_ready); end
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid c=%0d: got %b want 1", c, out_valid); end
                if (c == 5) held = {bout, diff};
                else begin
                    total++; if ({bout, diff} !== held) begin bad++; $display("FAIL bp_hold c=%0d: got %h want %h", c, {bout, diff}, held); end
                end
            end
            take = in_valid && in_ready;
            if (take) begin exp_q.push_back(model(a, b)); accepted++; end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL bp_extra: got %h/%b want nothing", diff, bout); end
                else begin
                    e = exp_q.pop_front();
                    if ({bout, diff} !== e) begin bad++; $display("FAIL bp_data: got %b/%h want %b/%h", bout, diff, e[16], e[15:0]); end
                end
            end
            next_cycle();
            if (take) begin a = 16'($urandom); b = 16'($urandom); end
            c++;
        end
        total++; if (c >= 200) begin bad++; $display("FAIL bp_timeout: got %0d pending want 0", exp_q.size()); end
        in_valid = 1'b0; out_ready = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
            next_cycle();
        end
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid: got %b want 1", out_valid); end
        next_cycle();
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        total++; if (diff !== 16'h0000) begin bad++; $display("FAIL rmid_diff: got %h want 0000", diff); end
        total++; if (bout !== 1'b0) begin bad++; $display("FAIL rmid_bout: got %b want 0", bout); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_ghost c=%0d: got %b want 0", c, out_valid); end
            next_cycle();
        end
    endtask

    // All low-nibble pairs with the upper bits fixed at 0xFFF, under random backpressure.
    task automatic test_exhaustive();
        int idx = 0;
        int c = 0;
        logic take;
        logic [7:0] v;
        logic [16:0] e;
        v = 8'd0;
        a = {12'hFFF, v[7:4]}; b = {12'hFFF, v[3:0]};
        while ((idx < 256 || exp_q.size() != 0) && c < 3000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = (idx < 256);
            @(negedge clk);
            take = in_valid && in_ready;
            if (take) begin exp_q.push_back(model(a, b)); idx++; end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL exh_extra: got %h/%b want nothing", diff, bout); end
                else begin
                    e = exp_q.pop_front();
                    if ({bout, diff} !== e) begin bad++; $display("FAIL exh_data: got %b/%h want %b/%h", bout, diff, e[16], e[15:0]); end
                end
            end
            next_cycle();
            if (take) begin
                v = 8'(idx);
                a = {12'hFFF, v[7:4]}; b = {12'hFFF, v[3:0]};
            end
            c++;
        end
        total++; if (c >= 3000) begin bad++; $display("FAIL exh_timeout: got %0d pending want 0", exp_q.size()); end
        in_valid = 1'b0; out_ready = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prefix_subtractor_pipe_16u.md
PREFIX_SUBTRACTOR_PIPE_16U -- requirements
Module: prefix_subtractor_pipe_16u

Interface
REQ-001 Parameters: none. Width is fixed at 16 bits and the pipeline depth is fixed at 2 register stages.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 a  input  16  minuend, unsigned.
REQ-007 b  input  16  subtrahend, unsigned.
REQ-008 out_valid  output  1  diff/bout hold a result.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 diff  output  16  a - b modulo 2^16 (saturated when REQ-031 applies).
REQ-011 bout  output  1  borrow out; 1 iff a < b unsigned.

Function
REQ-012 Arithmetic: a + ~b + 1, i.e. carry-in = 1. bout = NOT(final carry out of bit 15).
REQ-013 Carry network: Kogge-Stone prefix, 4 levels (spans 1, 2, 4, 8). Each bit i has generate g = a[i] & ~b[i] and propagate p = a[i] ^ ~b[i]. Carry-in enters as g = 1 at a virtual position -1.
REQ-014 Stage 1 registers p, g and the group (G,P) after prefix levels 1-2, plus a valid bit s1_v.
REQ-015 Stage 2 computes prefix levels 3-4 and the sum XOR, then registers diff, bout and out_valid.
REQ-016 Transfer rules: input transfers when in_valid & in_ready; output transfers when out_valid & out_ready.
REQ-017 Latency: an accepted pair appears on diff/bout exactly 2 cycles later if no backpressure occurs.
REQ-018 Throughput: 1 result per cycle while out_ready = 1.
REQ-019 Stage-2 load: stage 2 loads when (!out_valid | out_ready). The load enable is s2_en = (!out_valid | out_ready).
REQ-020 Stage-1 load: stage 1 loads when (!s1_v | s2_en).
REQ-021 in_ready: in_ready = !s1_v | s2_en. It is combinational from out_ready and registered state only, never from in_valid.
REQ-022 Stall: while out_valid = 1 and out_ready = 0, diff, bout and out_valid are held stable. Stage 1 holds its contents if s1_v = 1. No result is lost or duplicated.
REQ-023 Simultaneous accept and drain with both stages full and out_ready = 1: the new input enters stage 1, stage 1 moves to stage 2, and the old result leaves, all in the same cycle.
REQ-024 Bubbles: when stage 1 is empty and stage 2 advances, out_valid deasserts the next cycle.
REQ-025 Boundary cases: a = b gives diff = 0, bout = 0. a = 0, b = 0xFFFF gives diff = 0x0001, bout = 1. a = 0xFFFF, b = 0 gives diff = 0xFFFF, bout = 0.
REQ-026 Invalid inputs: a and b are ignored when in_valid = 0. Datapath registers update only on their load enable.

Reset
REQ-027 rst = 1 at a clock edge clears s1_v and out_valid to 0. It also clears diff to 0x0000 and bout to 0. It takes priority over every load.
REQ-028 Reset mid-operation: all in-flight pairs are discarded, and no result from them is ever presented.
REQ-029 in_ready = 1 in the first cycle after rst deasserts.
REQ-030 Stage-1 datapath registers need no reset. Their contents are don't-care while s1_v = 0.

Configuration
REQ-031 Macro SUB_SATURATE_EN, when defined: diff = 0x0000 whenever bout = 1, and bout is still reported.
REQ-032 When SUB_SATURATE_EN is undefined: diff is the modulo-2^16 result with no extra logic. Latency and handshake are identical in both builds.

Verification
REQ-033 Single op: rst, then a = 0x1234, b = 0x0234, in_valid for 1 cycle, out_ready = 1 -> out_valid = 1 at cycle +2 with diff = 0x1000, bout = 0, then out_valid = 0.
REQ-034 Borrow: a = 0x0000, b = 0x0001 -> diff = 0xFFFF, bout = 1. With SUB_SATURATE_EN defined -> diff = 0x0000, bout = 1.
REQ-035 Streaming: 64 random pairs back-to-back, out_ready = 1 -> 64 consecutive results in order with zero bubbles, each matching the reference a - b.
REQ-036 Backpressure: out_ready = 0 for 5 cycles during a stream -> in_ready drops once both stages are full, diff is held stable, and after release all results arrive in order with no loss or duplication.
REQ-037 Reset mid-stream: assert rst with 2 pairs in flight -> out_valid = 0, diff = 0, bout = 0 the next cycle, and neither pair ever appears.
REQ-038 Exhaustive low nibble: all 256 combinations with a[15:4] = b[15:4] = 0xFFF -> every diff and bout matches the reference model.
